// File: rtl/ifu_pkg.sv
// Shared constants, default geometry and FSM state type for the IFU instruction cache.
// Optional hit/miss counters in ifu_icache are enabled by defining IFU_ICACHE_STATS_EN.
package ifu_pkg;

    localparam logic HIT   = 1'b1;
    localparam logic MISS  = 1'b0;
    localparam logic VALID = 1'b1;

    localparam int NUM_LINES_D   = 16;
    localparam int LINE_WIDTH_D  = 128;
    localparam int ADDR_WIDTH_D  = 32;
    localparam int INSTR_WIDTH_D = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_FILL
    } icache_state_t;

endpackage

// File: rtl/ifu_icache_if.sv
// Fetch-side and fabric-side handshake bundle of the instruction cache.
// The cache uses the slave view; the core/fabric side uses the master view.
interface ifu_icache_if
    import ifu_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_D,
    parameter int INSTR_WIDTH = INSTR_WIDTH_D,
    parameter int LINE_WIDTH  = LINE_WIDTH_D
);

    logic                   core_req_valid;
    logic [ADDR_WIDTH-1:0]  core_req_addr;
    logic                   core_req_ready;
    logic                   core_rsp_valid;
    logic [INSTR_WIDTH-1:0] core_rsp_instr;
    logic                   mem_req_valid;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_req_ready;
    logic                   mem_rsp_valid;
    logic [LINE_WIDTH-1:0]  mem_rsp_data;

    modport slave (
        input  core_req_valid, core_req_addr,
        output core_req_ready, core_rsp_valid, core_rsp_instr,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output core_req_valid, core_req_addr,
        input  core_req_ready, core_rsp_valid, core_rsp_instr,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

endinterface

// File: rtl/ifu_icache_tag_cam.sv
// Fully-associative tag compare: hit lookup plus lowest-index free line search.
module ifu_icache_tag_cam #(
    parameter int NUM_LINES = 16,
    parameter int TAG_WIDTH = 28,
    parameter int P_BITS    = $clog2(NUM_LINES)
) (
    input  logic [NUM_LINES-1:0][TAG_WIDTH-1:0] tags,
    input  logic [NUM_LINES-1:0]                valid,
    input  logic [TAG_WIDTH-1:0]                tag,
    output logic                                hit,
    output logic [P_BITS-1:0]                   hit_idx,
    output logic [P_BITS-1:0]                   first_invalid_idx,
    output logic                                any_invalid
);

    // Walk downwards so the lowest matching / free index wins.
    always_comb begin
        hit               = 1'b0;
        hit_idx           = '0;
        first_invalid_idx = '0;
        any_invalid       = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == tag) begin
                hit     = 1'b1;
                hit_idx = P_BITS'(i);
            end
            if (!valid[i]) begin
                any_invalid       = 1'b1;
                first_invalid_idx = P_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/ifu_icache.sv
// Fully-associative IFU instruction cache with miss/fill FSM, round-robin victim and flush.
// Define IFU_ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt ports.
module ifu_icache
    import ifu_pkg::*;
#(
    parameter int NUM_LINES   = NUM_LINES_D,
    parameter int LINE_WIDTH  = LINE_WIDTH_D,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_D,
    parameter int INSTR_WIDTH = INSTR_WIDTH_D
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        flush,
    ifu_icache_if.slave bus
`ifdef IFU_ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int P_BITS       = $clog2(NUM_LINES);
    localparam int WORDS        = LINE_WIDTH / INSTR_WIDTH;
    localparam int WSEL_LSB     = $clog2(INSTR_WIDTH / 8);
    localparam int WSEL_W       = OFFSET_WIDTH - WSEL_LSB;

    typedef logic [NUM_LINES-1:0][TAG_WIDTH-1:0] tag_arr_t;
    typedef logic [WORDS-1:0][INSTR_WIDTH-1:0]   line_t;
    typedef line_t                               data_arr_t [NUM_LINES];

    icache_state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    tag_arr_t             tags_q;
    data_arr_t            data_q;
    logic [P_BITS-1:0]    rr_q;
    logic [TAG_WIDTH-1:0] miss_tag_q;
    logic [WSEL_W-1:0]    miss_wsel_q;
    logic                 drop_q;
    logic                 rsp_valid_q;
    logic [INSTR_WIDTH-1:0] rsp_instr_q;

    logic [TAG_WIDTH-1:0] req_tag;
    logic [WSEL_W-1:0]    req_wsel;
    logic                 addr_unused;
    logic                 hit;
    logic [P_BITS-1:0]    hit_idx;
    logic [P_BITS-1:0]    free_idx;
    logic                 any_invalid;
    logic [P_BITS-1:0]    victim;
    line_t                line_in;
    logic                 accept;
    logic                 fill;
    logic                 alloc;
    logic                 in_miss;

    assign req_tag     = bus.core_req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign req_wsel    = bus.core_req_addr[OFFSET_WIDTH-1:WSEL_LSB];
    assign addr_unused = ^bus.core_req_addr[WSEL_LSB-1:0];
    assign line_in     = bus.mem_rsp_data;

    ifu_icache_tag_cam #(
        .NUM_LINES (NUM_LINES),
        .TAG_WIDTH (TAG_WIDTH),
        .P_BITS    (P_BITS)
    ) u_cam (
        .tags              (tags_q),
        .valid             (valid_q),
        .tag               (req_tag),
        .hit               (hit),
        .hit_idx           (hit_idx),
        .first_invalid_idx (free_idx),
        .any_invalid       (any_invalid)
    );

    assign bus.core_req_ready = (state_q == S_IDLE) & ~flush & ~Rst;
    assign bus.core_rsp_valid = rsp_valid_q;
    assign bus.core_rsp_instr = rsp_instr_q;
    assign bus.mem_req_valid  = (state_q == S_MISS_REQ);
    assign bus.mem_req_addr   = bus.mem_req_valid
                              ? {miss_tag_q, {OFFSET_WIDTH{1'b0}}}
                              : '0;

    assign accept  = bus.core_req_valid & bus.core_req_ready;
    assign in_miss = (state_q == S_MISS_REQ) | (state_q == S_MISS_WAIT);
    assign fill    = (state_q == S_MISS_WAIT) & bus.mem_rsp_valid;
    // A flush landing on the fill edge must also suppress allocation.
    assign alloc   = fill & ~drop_q & ~flush;
    assign victim  = any_invalid ? free_idx : rr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (accept && hit == MISS) state_d = S_MISS_REQ;
            S_MISS_REQ:  if (bus.mem_req_ready) state_d = S_MISS_WAIT;
            S_MISS_WAIT: if (bus.mem_rsp_valid) state_d = S_FILL;
            S_FILL:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            rr_q        <= '0;
            miss_tag_q  <= '0;
            miss_wsel_q <= '0;
            drop_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                miss_tag_q  <= req_tag;
                miss_wsel_q <= req_wsel;
                if (hit == HIT) begin
                    rsp_valid_q <= 1'b1;
                    rsp_instr_q <= data_q[hit_idx][req_wsel];
                end
            end
            if (fill) begin
                rsp_valid_q <= 1'b1;
                rsp_instr_q <= line_in[miss_wsel_q];
            end
            if (alloc) begin
                valid_q[victim] <= VALID;
                if (!any_invalid) rr_q <= rr_q + 1'b1;
            end
            if (flush && in_miss) drop_q <= 1'b1;
            else if (state_q == S_FILL) drop_q <= 1'b0;
            if (flush) valid_q <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (alloc) begin
            tags_q[victim] <= miss_tag_q;
            data_q[victim] <= line_in;
        end
    end

`ifdef IFU_ICACHE_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit == HIT && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (hit == MISS && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_icache.sv
// Randomised + directed bench for ifu_icache against a line-level reference model.
module tb_ifu_icache;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    ifu_icache_if bus ();

`ifdef IFU_ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    ifu_icache dut (
        .Clk   (clk),
        .Rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef IFU_ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: 16 lines of (valid, tag), round-robin pointer.
    bit          mv [16];
    logic [27:0] mt [16];
    int          rr;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [27:0] t);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = {4'(k) ^ 4'hC, t};
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [127:0] l;
        l = line_of(a[31:4]);
        return l[a[3:2]*32 +: 32];
    endfunction

    function automatic bit m_hit(input logic [27:0] t);
        for (int i = 0; i < 16; i++) if (mv[i] && mt[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endfunction

    function automatic void m_fill(input logic [27:0] t);
        for (int i = 0; i < 16; i++) begin
            if (!mv[i]) begin
                mv[i] = 1'b1;
                mt[i] = t;
                return;
            end
        end
        mt[rr] = t;
        mv[rr] = 1'b1;
        rr = (rr + 1) % 16;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.core_req_ready, 0);
        chk("rst_rsp_valid", bus.core_rsp_valid, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 0);
        chk("rst_rsp_instr", bus.core_rsp_instr, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.core_req_ready, 1);
        m_clear();
        rr = 0;
    endtask

    // Entered at posedge+1 with the DUT idle; returns at posedge+1, DUT idle.
    task automatic fetch(input logic [31:0] a, input int stall,
                         input int lat, input bit fl);
        bit          h;
        logic [31:0] la;
        la = {a[31:4], 4'h0};
        h  = m_hit(a[31:4]);
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = a;
        #1;
        chk("req_ready", bus.core_req_ready, 1);
        @(posedge clk);
        #1;
        bus.core_req_valid = 1'b0;
        bus.core_req_addr  = $urandom;
        if (h) begin
            chk("hit_rsp_valid", bus.core_rsp_valid, 1);
            chk("hit_instr", bus.core_rsp_instr, exp_word(a));
            chk("hit_no_mem_req", bus.mem_req_valid, 0);
        end else begin
            chk("miss_rsp_valid", bus.core_rsp_valid, 0);
            chk("mem_req_valid", bus.mem_req_valid, 1);
            chk("mem_req_addr", bus.mem_req_addr, la);
            chk("miss_ready", bus.core_req_ready, 0);
            repeat (stall) begin
                bus.mem_req_ready = 1'b0;
                @(posedge clk);
                #1;
                chk("stall_req_valid", bus.mem_req_valid, 1);
                chk("stall_req_addr", bus.mem_req_addr, la);
                chk("stall_ready", bus.core_req_ready, 0);
            end
            bus.mem_req_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.mem_req_ready = 1'b0;
            chk("wait_req_drop", bus.mem_req_valid, 0);
            chk("wait_ready", bus.core_req_ready, 0);
            if (fl) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                m_clear();
            end
            repeat (lat) begin
                @(posedge clk);
                #1;
            end
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = line_of(a[31:4]);
            @(posedge clk);
            #1;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = {4{$urandom}};
            chk("fill_rsp_valid", bus.core_rsp_valid, 1);
            chk("fill_instr", bus.core_rsp_instr, exp_word(a));
            chk("fill_ready", bus.core_req_ready, 0);
            @(posedge clk);
            #1;
            chk("post_fill_rsp", bus.core_rsp_valid, 0);
            chk("post_fill_ready", bus.core_req_ready, 1);
            if (!fl) m_fill(a[31:4]);
        end
    endtask

    task automatic flush_idle(input logic [31:0] a);
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = a;
        flush = 1'b1;
        #1;
        chk("flush_idle_ready", bus.core_req_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.core_req_valid = 1'b0;
        chk("flush_idle_no_rsp", bus.core_rsp_valid, 0);
        chk("flush_idle_no_mem", bus.mem_req_valid, 0);
        m_clear();
    endtask

    initial begin
        logic [31:0] stream [3];
        logic [31:0] a;
        bus.core_req_valid = 1'b0;
        bus.core_req_addr  = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        m_clear();
        rr = 0;
        do_reset();

        // Cold miss returning word 2
        fetch(32'h0000_1008, 0, 1, 1'b0);

        // Back-to-back hit stream
        stream = '{32'h0000_1000, 32'h0000_1004, 32'h0000_100C};
        bus.core_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.core_req_addr = stream[i];
            #1;
            chk("stream_ready", bus.core_req_ready, 1);
            @(posedge clk);
            #1;
            chk("stream_rsp_valid", bus.core_rsp_valid, 1);
            chk("stream_instr", bus.core_rsp_instr, exp_word(stream[i]));
            chk("stream_no_mem", bus.mem_req_valid, 0);
        end
        bus.core_req_valid = 1'b0;
`ifdef IFU_ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 3);
        chk("miss_cnt", miss_cnt, 1);
`endif

        // Replacement: 17 distinct lines, then revisit
        do_reset();
        for (int t = 0; t < 17; t++) fetch({28'h100 + 28'(t), 4'h4}, 0, 0, 1'b0);
        fetch({28'h100, 4'h0}, 0, 0, 1'b0);
        fetch({28'h102, 4'h8}, 0, 0, 1'b0);
        fetch({28'h101, 4'hC}, 0, 0, 1'b0);
        fetch({28'h103, 4'h0}, 0, 0, 1'b0);

        // Fabric stall
        fetch(32'h0000_2004, 5, 2, 1'b0);
        fetch(32'h0000_2000, 0, 0, 1'b0);

        // Flush mid-miss, then the same address misses again
        fetch(32'h0000_3008, 1, 1, 1'b1);
        fetch(32'h0000_3008, 0, 0, 1'b0);
        fetch(32'h0000_3004, 0, 0, 1'b0);
        flush_idle(32'h0000_3004);
        fetch(32'h0000_3004, 0, 0, 1'b0);

        // Reset during MISS_WAIT, then a stray fill
        fetch(32'h0000_4000, 0, 0, 1'b0);
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = 32'h0000_5000;
        @(posedge clk);
        #1;
        bus.core_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_req_valid", bus.mem_req_valid, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = line_of(28'h500);
        @(posedge clk);
        #1;
        bus.mem_rsp_valid = 1'b0;
        chk("stray_no_rsp", bus.core_rsp_valid, 0);
        chk("stray_ready", bus.core_req_ready, 1);
        chk("stray_no_mem", bus.mem_req_valid, 0);
        m_clear();
        rr = 0;
        fetch(32'h0000_4000, 0, 0, 1'b0);
        fetch(32'h0000_5000, 0, 0, 1'b0);

        // Random traffic over 24 tags
        for (int n = 0; n < 150; n++) begin
            a = {28'h300 + 28'($urandom_range(0, 23)), 4'($urandom)};
            if ($urandom_range(0, 19) == 0) flush_idle(a);
            fetch(a, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
